// File: rtl/sr_ctrl_pkg.sv
// Shared encodings for the SR flag arbiter.
//   state_t : controller FSM states (IDLE=0, APPLY=1)
//   op_t    : requester operation codes (OP_CLR=0, OP_SET=1)
package sr_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  typedef enum logic {
    OP_CLR = 1'b0,
    OP_SET = 1'b1
  } op_t;

endpackage

// File: rtl/sr_cell.sv
// One SR flag bit.
//   clk, rst : clock, asynchronous active-high reset (q -> 0)
//   s, r     : 00 hold, 10 set, 01 clear (11 never driven by the controller)
//   q, qbar  : stored value and its complement
module sr_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic qbar
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)    q <= 1'b0;
    else if (s) q <= 1'b1;
    else if (r) q <= 1'b0;
  end

  assign qbar = ~q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// Round-robin arbiter that lets NREQ requesters set or clear bits of a
// shared SR flag bank, one operation per two cycles.
//   clk, rst  : clock, asynchronous active-high reset
//   req       : per-requester request, held until gnt is seen
//   op        : per-requester operation (1 set, 0 clear)
//   idx       : flattened flag index, requester i at [i*IDXW +: IDXW]
//   clr_all   : synchronous clear of every flag and of collide
//   gnt       : registered one-hot grant, one cycle wide
//   flags     : flag bank values, flags_n their complement
//   busy      : high while an operation is being applied
//   collide   : sticky, opposite ops to one index seen in one arbitration
module sr_flag_arbiter
  import sr_ctrl_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  localparam int IDXW = (NFLAG > 1) ? $clog2(NFLAG) : 1,
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic                 clr_all,
  output logic [NREQ-1:0]      gnt,
  output logic [NFLAG-1:0]     flags,
  output logic [NFLAG-1:0]     flags_n,
  output logic                 busy,
  output logic                 collide
);

  state_t          state, state_nxt;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   winner;
  logic            win_found;
  op_t             lat_op;
  logic [IDXW-1:0] lat_idx;
  logic            coll_now;
  logic [NFLAG-1:0] cell_s, cell_r;
  int              cand;

  // Round-robin pick: first requester at or after last_grant+1, wrapping.
  always_comb begin
    winner    = last_grant;
    win_found = 1'b0;
    cand      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_grant) + k) % NREQ;
      if (!win_found && req[cand]) begin
        winner    = GW'(cand);
        win_found = 1'b1;
      end
    end
  end

  // Any two requesting lanes aiming opposite ops at one index.
  always_comb begin
    coll_now = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (req[i] && req[j] && (op[i] != op[j]) &&
            (idx[i*IDXW +: IDXW] == idx[j*IDXW +: IDXW]))
          coll_now = 1'b1;
      end
    end
  end

  // Next state and cell drive. clr_all is carried out by pulsing r on every
  // cell; s is only ever driven for the single latched set, so s and r are
  // mutually exclusive per cell by construction.
  always_comb begin
    state_nxt = state;
    cell_s    = '0;
    cell_r    = '0;
    case (state)
      IDLE: begin
        if (clr_all)   cell_r    = '1;
        else if (|req) state_nxt = APPLY;
      end
      APPLY: begin
        state_nxt = IDLE;
        if (clr_all)               cell_r          = '1;
        else if (lat_op == OP_SET) cell_s[lat_idx] = 1'b1;
        else                       cell_r[lat_idx] = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      last_grant <= GW'(NREQ - 1);
      lat_op     <= OP_CLR;
      lat_idx    <= '0;
      collide    <= 1'b0;
    end else begin
      state <= state_nxt;
      gnt   <= '0;
      if (clr_all) begin
        collide <= 1'b0;
      end else if (state == IDLE && win_found) begin
        gnt        <= NREQ'(1) << winner;
        last_grant <= winner;
        lat_op     <= op_t'(op[int'(winner)]);
        lat_idx    <= idx[int'(winner)*IDXW +: IDXW];
        collide    <= collide | coll_now;
      end
    end
  end

  assign busy = (state == APPLY);

  for (genvar g = 0; g < NFLAG; g++) begin : g_cell
    sr_cell u_cell (
      .clk  (clk),
      .rst  (rst),
      .s    (cell_s[g]),
      .r    (cell_r[g]),
      .q    (flags[g]),
      .qbar (flags_n[g])
    );
  end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Self-checking bench for sr_flag_arbiter: directed scenarios plus a
// randomized transaction run against a transaction-level model.
module tb_sr_flag_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IDXW  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      op;
  logic [NREQ*IDXW-1:0] idx;
  logic                 clr_all;
  logic [NREQ-1:0]      gnt;
  logic [NFLAG-1:0]     flags;
  logic [NFLAG-1:0]     flags_n;
  logic                 busy;
  logic                 collide;

  int total = 0;
  int bad   = 0;

  // model state
  logic [NFLAG-1:0] m_flags;
  logic             m_coll;
  int               m_last;

  always #5 clk = ~clk;

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .op      (op),
    .idx     (idx),
    .clr_all (clr_all),
    .gnt     (gnt),
    .flags   (flags),
    .flags_n (flags_n),
    .busy    (busy),
    .collide (collide)
  );

  // Invariants checked every cycle outside reset.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      total++;
      if (((dut.cell_s & dut.cell_r) !== '0) || !$onehot0(gnt) || (flags_n !== ~flags)) begin
        bad++;
        $display("FAIL invariant s=%b r=%b gnt=%b flags=%h flags_n=%h (need s&r=0, gnt one-hot/zero, flags_n=~flags)",
                 dut.cell_s, dut.cell_r, gnt, flags, flags_n);
      end
    end
  end

  function automatic logic [NREQ*IDXW-1:0] pack(input int a, input int b, input int c, input int d);
    logic [2:0] a3, b3, c3, d3;
    a3 = a[2:0]; b3 = b[2:0]; c3 = c[2:0]; d3 = d[2:0];
    return {d3, c3, b3, a3};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; op = '0; idx = '0; clr_all = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_flags = '0; m_coll = 1'b0; m_last = NREQ - 1;
  endtask

  // single unchecked operation through one lane (2 cycles)
  task automatic issue(input int lane, input logic o, input int i);
    req = '0; op = '0; idx = '0;
    req[lane] = 1'b1;
    op[lane]  = o;
    idx[lane*IDXW +: IDXW] = i[IDXW-1:0];
    step();
    req = '0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; op = '0; idx = '0; clr_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({gnt, flags, flags_n, busy, collide} !== {4'b0000, 8'h00, 8'hFF, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got gnt=%b flags=%h flags_n=%h busy=%b collide=%b exp 0000/00/ff/0/0",
               gnt, flags, flags_n, busy, collide);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; op = 4'b0001; idx = pack(3, 0, 0, 0);
    step();
    total++;
    if (gnt !== 4'b0001 || busy !== 1'b1 || flags !== 8'h00) begin
      bad++;
      $display("FAIL single_edge1 gnt=%b busy=%b flags=%h exp 0001/1/00", gnt, busy, flags);
    end
    req = '0;
    step();
    total++;
    if (flags !== 8'h08 || flags_n !== 8'hF7 || gnt !== 4'b0000 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_edge2 flags=%h flags_n=%h gnt=%b busy=%b exp 08/f7/0000/0", flags, flags_n, gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [7:0] ef;
    do_reset();
    req = 4'b1111; op = 4'b1111; idx = pack(0, 1, 2, 3);
    for (int n = 0; n < 4; n++) begin
      step();
      eg = 4'(1 << n);
      total++;
      if (gnt !== eg) begin
        bad++;
        $display("FAIL rr_grant%0d got=%b exp=%b", n, gnt, eg);
      end
      step();
      ef = 8'((1 << (n + 1)) - 1);
      total++;
      if (gnt !== 4'b0000 || flags !== ef) begin
        bad++;
        $display("FAIL rr_apply%0d gnt=%b flags=%h exp 0000/%h", n, gnt, flags, ef);
      end
    end
    step();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL rr_wrap got=%b exp=0001", gnt);
    end
    req = '0;
    step();
    total++;
    if (flags !== 8'h0F) begin
      bad++;
      $display("FAIL rr_final flags=%h exp=0f", flags);
    end
  endtask

  task automatic test_collide();
    do_reset();
    for (int i = 0; i < 8; i++) issue(3, 1'b1, i);
    total++;
    if (flags !== 8'hFF || collide !== 1'b0) begin
      bad++;
      $display("FAIL coll_setup flags=%h collide=%b exp ff/0", flags, collide);
    end
    req = 4'b0011; op = 4'b0010; idx = pack(5, 5, 0, 0);
    step();
    total++;
    if (gnt !== 4'b0001 || collide !== 1'b1) begin
      bad++;
      $display("FAIL coll_grant0 gnt=%b collide=%b exp 0001/1", gnt, collide);
    end
    req = 4'b0010;
    step();
    total++;
    if (flags !== 8'hDF) begin
      bad++;
      $display("FAIL coll_clear flags=%h exp=df", flags);
    end
    step();
    total++;
    if (gnt !== 4'b0010) begin
      bad++;
      $display("FAIL coll_grant1 gnt=%b exp=0010", gnt);
    end
    req = '0;
    step();
    total++;
    if (flags !== 8'hFF || collide !== 1'b1) begin
      bad++;
      $display("FAIL coll_final flags=%h collide=%b exp ff/1", flags, collide);
    end
  endtask

  task automatic test_clr_all();
    do_reset();
    issue(0, 1'b1, 0);
    req = 4'b0110; op = 4'b0010; idx = pack(0, 7, 7, 0);
    step();
    total++;
    if (gnt !== 4'b0010 || busy !== 1'b1 || collide !== 1'b1 || flags !== 8'h01) begin
      bad++;
      $display("FAIL clr_setup gnt=%b busy=%b collide=%b flags=%h exp 0010/1/1/01", gnt, busy, collide, flags);
    end
    req = '0; clr_all = 1'b1;
    step();
    total++;
    if (flags !== 8'h00 || collide !== 1'b0 || busy !== 1'b0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL clr_apply flags=%h collide=%b busy=%b gnt=%b exp 00/0/0/0000", flags, collide, busy, gnt);
    end
    clr_all = 1'b0;
    step();
    total++;
    if (flags !== 8'h00 || busy !== 1'b0 || gnt !== 4'b0000) begin
      bad++;
      $display("FAIL clr_hold flags=%h busy=%b gnt=%b exp 00/0/0000", flags, busy, gnt);
    end
    issue(0, 1'b1, 2);
    req = 4'b0001; op = 4'b0001; idx = pack(6, 0, 0, 0); clr_all = 1'b1;
    step();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || flags !== 8'h00) begin
      bad++;
      $display("FAIL clr_idle gnt=%b busy=%b flags=%h exp 0000/0/00", gnt, busy, flags);
    end
    clr_all = 1'b0; req = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(3, 1'b1, 1);
    req = 4'b0100; op = 4'b0100; idx = pack(0, 0, 4, 0);
    step();
    total++;
    if (gnt !== 4'b0100 || busy !== 1'b1 || flags !== 8'h02) begin
      bad++;
      $display("FAIL areset_setup gnt=%b busy=%b flags=%h exp 0100/1/02", gnt, busy, flags);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (flags !== 8'h00 || flags_n !== 8'hFF || gnt !== 4'b0000 || busy !== 1'b0 || collide !== 1'b0) begin
      bad++;
      $display("FAIL areset_now flags=%h flags_n=%h gnt=%b busy=%b collide=%b exp 00/ff/0000/0/0",
               flags, flags_n, gnt, busy, collide);
    end
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1111; op = 4'b1111; idx = pack(0, 1, 2, 3);
    step();
    total++;
    if (gnt !== 4'b0001) begin
      bad++;
      $display("FAIL areset_first gnt=%b exp=0001", gnt);
    end
    req = '0;
    step();
    total++;
    if (flags !== 8'h01) begin
      bad++;
      $display("FAIL areset_after flags=%h exp=01", flags);
    end
  endtask

  task automatic test_random();
    int w, wi;
    logic wop, cl, eb;
    logic [3:0] eg;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      req = 4'($urandom); op = 4'($urandom); idx = 12'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        clr_all = 1'b1;
        step();
        m_flags = '0; m_coll = 1'b0;
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || flags !== m_flags || collide !== m_coll) begin
          bad++;
          $display("FAIL rand_clr_idle t=%0d gnt=%b busy=%b flags=%h collide=%b exp 0000/0/%h/%b",
                   t, gnt, busy, flags, collide, m_flags, m_coll);
        end
        clr_all = 1'b0;
      end else if (req == '0) begin
        step();
        total++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || flags !== m_flags || collide !== m_coll) begin
          bad++;
          $display("FAIL rand_idle t=%0d gnt=%b busy=%b flags=%h collide=%b exp 0000/0/%h/%b",
                   t, gnt, busy, flags, collide, m_flags, m_coll);
        end
      end else begin
        w = -1;
        for (int k = 1; k <= NREQ; k++)
          if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
        for (int i = 0; i < NREQ; i++)
          for (int j = i + 1; j < NREQ; j++)
            if (req[i] && req[j] && op[i] != op[j] &&
                idx[i*IDXW +: IDXW] == idx[j*IDXW +: IDXW]) m_coll = 1'b1;
        m_last = w;
        wop = op[w];
        wi  = int'(idx[w*IDXW +: IDXW]);
        eg  = 4'(1 << w);
        step();
        total++;
        if (gnt !== eg || busy !== 1'b1 || collide !== m_coll) begin
          bad++;
          $display("FAIL rand_grant t=%0d gnt=%b busy=%b collide=%b exp %b/1/%b", t, gnt, busy, collide, eg, m_coll);
        end
        // inputs during the apply cycle are ignored, except clr_all
        req = 4'($urandom); op = 4'($urandom); idx = 12'($urandom);
        cl = ($urandom_range(0, 7) == 0);
        clr_all = cl;
        step();
        if (cl) begin
          m_flags = '0; m_coll = 1'b0;
        end else begin
          m_flags[wi] = wop;
        end
        eb = 1'b0;
        total++;
        if (flags !== m_flags || collide !== m_coll || gnt !== 4'b0000 || busy !== eb) begin
          bad++;
          $display("FAIL rand_apply t=%0d flags=%h collide=%b gnt=%b busy=%b exp %h/%b/0000/0",
                   t, flags, collide, gnt, busy, m_flags, m_coll);
        end
        clr_all = 1'b0;
      end
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; idx = '0; clr_all = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_collide();
    test_clr_all();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
